// File: rtl/threshold_integrator_multi.sv
// Multi-channel rolling-window magnitude integrator with a latched over-threshold shutdown.
// Per-channel block sums feed a shared ring; each window total is updated one channel per cycle.
module threshold_integrator_multi #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LOG2_WINDOW = 12,
  parameter int unsigned LOG2_DECIM  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           signed_mode,
  input  logic [DATA_WIDTH-2:0]          threshold_average,
  input  logic [CHANNELS-1:0]            channel_mask,
  input  logic                           sample_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] value_in_concat,
  output logic                           running,
  output logic                           window_full,
  output logic                           over_threshold,
  output logic [CHANNELS-1:0]            over_threshold_channels,
  output logic                           err_overrun
);

  localparam int unsigned ACC_W      = DATA_WIDTH + LOG2_DECIM;
  localparam int unsigned TOT_W      = DATA_WIDTH + LOG2_WINDOW;
  localparam int unsigned PTR_W      = LOG2_WINDOW - LOG2_DECIM;
  localparam int unsigned K_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned RING_DEPTH = 2 ** (K_W + PTR_W);
  localparam logic [DATA_WIDTH-1:0] HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_UPDATE, S_HALT, S_ERROR} state_t;

  state_t                   state, state_next;
  logic                     cfg_signed;
  logic [TOT_W-1:0]         cfg_limit;
  logic [CHANNELS-1:0]      cfg_mask;
  logic [LOG2_DECIM-1:0]    cnt;
  logic [K_W-1:0]           k;
  logic [PTR_W-1:0]         wr_ptr;
  logic [ACC_W-1:0]         acc   [CHANNELS];
  logic [TOT_W-1:0]         total [CHANNELS];
  logic [ACC_W-1:0]         ring  [RING_DEPTH];
  logic [DATA_WIDTH-1:0]    mag   [CHANNELS];

  logic [K_W+PTR_W-1:0]     ring_idx;
  logic [ACC_W-1:0]         old_word;
  logic [TOT_W-1:0]         new_total;
  logic                     new_trip;
  logic [CHANNELS-1:0]      flags_next;
  logic                     last_ch;
  logic                     any_trip;
  logic                     ring_we;

  // Unsigned distance from the format's zero point; the most negative code maps to 2^(W-1).
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x,
                                                      input logic tc);
    if (tc) return x[DATA_WIDTH-1] ? DATA_WIDTH'(-x) : x;
    else    return x[DATA_WIDTH-1] ? DATA_WIDTH'(x - HALF) : DATA_WIDTH'(HALF - x);
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      mag[c] = magnitude(value_in_concat[DATA_WIDTH*(c+1)-1 -: DATA_WIDTH], cfg_signed);
    end
  end

  // Window update for channel k; stale ring slots are masked until the first wrap.
  always_comb begin
    ring_idx   = {k, wr_ptr};
    old_word   = window_full ? ring[ring_idx] : '0;
    new_total  = total[k] + TOT_W'(acc[k]) - TOT_W'(old_word);
    new_trip   = (new_total > cfg_limit) && cfg_mask[k];
    flags_next = over_threshold_channels | (CHANNELS'(new_trip) << k);
    last_ch    = (k == K_W'(CHANNELS - 1));
    any_trip   = |flags_next;
    ring_we    = (state == S_UPDATE) && !sample_valid && enable && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (enable) state_next = S_RUN;
      S_RUN:    if (sample_valid && (cnt == '1)) state_next = S_UPDATE;
      S_UPDATE: begin
        if (sample_valid)  state_next = S_ERROR;
        else if (last_ch)  state_next = any_trip ? S_HALT : S_RUN;
      end
      S_HALT:   state_next = S_HALT;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
    if (!enable) state_next = S_IDLE;
  end

  // Datapath and sticky status; dropping enable behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      running                 <= 1'b0;
      window_full             <= 1'b0;
      over_threshold          <= 1'b0;
      over_threshold_channels <= '0;
      err_overrun             <= 1'b0;
      cfg_signed              <= 1'b0;
      cfg_limit               <= '0;
      cfg_mask                <= '0;
      cnt                     <= '0;
      k                       <= '0;
      wr_ptr                  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]   <= '0;
        total[c] <= '0;
      end
    end else begin
      running <= (state_next == S_RUN) || (state_next == S_UPDATE);
      case (state)
        S_IDLE: begin
          cfg_signed <= signed_mode;
          cfg_limit  <= {1'b0, threshold_average, {LOG2_WINDOW{1'b0}}};
          cfg_mask   <= channel_mask;
        end
        S_RUN: begin
          if (sample_valid) begin
            for (int c = 0; c < CHANNELS; c++) acc[c] <= acc[c] + ACC_W'(mag[c]);
            cnt <= cnt + LOG2_DECIM'(1);
            k   <= '0;
          end
        end
        S_UPDATE: begin
          if (sample_valid) begin
            err_overrun <= 1'b1;
          end else begin
            total[k]                <= new_total;
            acc[k]                  <= '0;
            over_threshold_channels <= flags_next;
            if (last_ch) begin
              wr_ptr <= wr_ptr + PTR_W'(1);
              if (wr_ptr == '1) window_full <= 1'b1;
              if (any_trip) over_threshold <= 1'b1;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ring_we) ring[ring_idx] <= acc[k];
  end

endmodule

// File: tb/tb_threshold_integrator_multi.sv
// Bench for threshold_integrator_multi: vector table, hand-built corner sequences and
// randomized runs checked against a sample-history window model.
module tb_threshold_integrator_multi;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned LD = 2;
  localparam int WIN = 16;
  localparam int BLK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          signed_mode;
  logic [DW-2:0] threshold_average;
  logic [CH-1:0] channel_mask;
  logic          sample_valid;
  logic [CH*DW-1:0] value_in_concat;
  logic          running, window_full, over_threshold, err_overrun;
  logic [CH-1:0] over_threshold_channels;

  int checks = 0;
  int errors = 0;

  threshold_integrator_multi #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .LOG2_WINDOW(LW), .LOG2_DECIM(LD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .signed_mode(signed_mode),
    .threshold_average(threshold_average), .channel_mask(channel_mask),
    .sample_valid(sample_valid), .value_in_concat(value_in_concat),
    .running(running), .window_full(window_full), .over_threshold(over_threshold),
    .over_threshold_channels(over_threshold_channels), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Reference model: full magnitude history, window = most recent WIN samples.
  int      hist [CH][$];
  int      m_count;
  bit      m_halt, m_over, m_wf, m_sm;
  int      m_thr;
  bit [CH-1:0] m_mask, m_flags;

  function automatic int ref_mag(input logic [DW-1:0] x, input bit sm);
    int v;
    if (sm) v = $signed(x);
    else    v = int'(x) - 32768;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset(input bit sm, input int thr, input bit [CH-1:0] mask);
    for (int c = 0; c < CH; c++) hist[c].delete();
    m_count = 0; m_halt = 0; m_over = 0; m_wf = 0; m_flags = '0;
    m_sm = sm; m_thr = thr; m_mask = mask;
  endtask

  task automatic model_push(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    int s, n, lo;
    if (m_halt) return;
    hist[0].push_back(ref_mag(v0, m_sm));
    hist[1].push_back(ref_mag(v1, m_sm));
    m_count++;
    if (m_count % BLK != 0) return;
    for (int c = 0; c < CH; c++) begin
      s = 0; n = hist[c].size(); lo = (n > WIN) ? n - WIN : 0;
      for (int i = lo; i < n; i++) s += hist[c][i];
      if (s > m_thr * WIN && m_mask[c]) m_flags[c] = 1'b1;
    end
    if (m_count >= WIN) m_wf = 1;
    if (m_flags != 0) begin m_over = 1; m_halt = 1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input bit sm, input logic [DW-2:0] thr, input logic [CH-1:0] mask);
    enable = 1'b0; sample_valid = 1'b0;
    tick();
    signed_mode = sm; threshold_average = thr; channel_mask = mask; enable = 1'b1;
    tick();
    model_reset(sm, int'(thr), mask);
    check("start_running", 32'(running), 32'd1);
  endtask

  task automatic sample(input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    value_in_concat = {v1, v0}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (BLK - 1) tick();
    model_push(v0, v1);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_over"},  32'(over_threshold), 32'(m_over));
    check({tag, "_chans"}, 32'(over_threshold_channels), 32'(m_flags));
    check({tag, "_wfull"}, 32'(window_full), 32'(m_wf));
    check({tag, "_run"},   32'(running), 32'(!m_halt));
    check({tag, "_err"},   32'(err_overrun), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_zero"},
          32'({running, window_full, over_threshold, over_threshold_channels, err_overrun}), 32'd0);
  endtask

  typedef struct {
    bit          sm;
    logic [DW-2:0] thr;
    logic [CH-1:0] mask;
    logic [DW-1:0] v0, v1;
    int          n;
    bit          over;
    logic [CH-1:0] chans;
    bit          wf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // sm   thr      mask   v0       v1       n   over chans wf
    vecs[0] = '{1'b0, 15'd99,   2'b11, 16'h8064, 16'h8000, 16, 1'b1, 2'b01, 1'b1};
    vecs[1] = '{1'b0, 15'd100,  2'b11, 16'h8064, 16'h8000, 16, 1'b0, 2'b00, 1'b1};
    vecs[2] = '{1'b0, 15'd100,  2'b11, 16'h8064, 16'h8000, 24, 1'b0, 2'b00, 1'b1};
    vecs[3] = '{1'b1, 15'd1000, 2'b01, 16'h0000, 16'h8000, 4,  1'b0, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 15'd1000, 2'b11, 16'h0000, 16'h8000, 4,  1'b1, 2'b10, 1'b0};
    vecs[5] = '{1'b0, 15'h7FFF, 2'b11, 16'h8000, 16'h0000, 16, 1'b1, 2'b10, 1'b1};
    vecs[6] = '{1'b0, 15'd0,    2'b11, 16'h8000, 16'h8000, 16, 1'b0, 2'b00, 1'b1};
    vecs[7] = '{1'b1, 15'd0,    2'b01, 16'hFFFF, 16'h0001, 4,  1'b1, 2'b01, 1'b0};

    rst = 1'b1; enable = 1'b0; signed_mode = 1'b0; threshold_average = '0;
    channel_mask = '0; sample_valid = 1'b0; value_in_concat = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].sm, vecs[i].thr, vecs[i].mask);
      for (int s = 0; s < vecs[i].n; s++) sample(vecs[i].v0, vecs[i].v1);
      check($sformatf("vec%0d_over", i),  32'(over_threshold), 32'(vecs[i].over));
      check($sformatf("vec%0d_chans", i), 32'(over_threshold_channels), 32'(vecs[i].chans));
      check($sformatf("vec%0d_wfull", i), 32'(window_full), 32'(vecs[i].wf));
    end

    // Trip latency: channel flag one edge after acceptance, summary flag one edge later.
    start(1'b0, 15'd99, 2'b11);
    repeat (15) sample(16'h8064, 16'h8000);
    check("lat_pre_over", 32'(over_threshold), 32'd0);
    value_in_concat = {16'h8000, 16'h8064}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    check("lat_k0_chans", 32'(over_threshold_channels), 32'b01);
    check("lat_k0_over",  32'(over_threshold), 32'd0);
    tick();
    check("lat_k1_over",  32'(over_threshold), 32'd1);
    check("lat_halt_run", 32'(running), 32'd0);
    repeat (3) sample(16'h0000, 16'h0000);
    check("halt_frozen", 32'({over_threshold, over_threshold_channels, window_full}), 32'b1011);
    enable = 1'b0;
    tick();
    check_all_zero("disable");

    // Decaying window: one heavy block ages out after the ring wraps.
    start(1'b0, 15'd60, 2'b11);
    repeat (4) sample(16'h80C8, 16'h8000);
    check_model("decay_a");
    repeat (16) sample(16'h8000, 16'h8000);
    check_model("decay_b");
    check("decay_over", 32'(over_threshold), 32'd0);

    // Overrun: second strobe one cycle after the block-completing sample.
    start(1'b0, 15'd0, 2'b11);
    repeat (3) sample(16'h8064, 16'h8064);
    value_in_concat = {16'h8064, 16'h8064}; sample_valid = 1'b1;
    tick();
    tick();
    sample_valid = 1'b0;
    tick();
    check("ovr_err",   32'(err_overrun), 32'd1);
    check("ovr_run",   32'(running), 32'd0);
    check("ovr_chans", 32'(over_threshold_channels), 32'd0);
    check("ovr_over",  32'(over_threshold), 32'd0);
    repeat (4) sample(16'hFFFF, 16'hFFFF);
    check("ovr_frozen", 32'({err_overrun, over_threshold, over_threshold_channels}), 32'b1000);

    // Reset during UPDATE, then a fresh run must reproduce the basic trip.
    start(1'b0, 15'd0, 2'b11);
    repeat (3) sample(16'h8064, 16'h8064);
    value_in_concat = {16'h8064, 16'h8064}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0; rst = 1'b1;
    signed_mode = 1'b0; threshold_average = 15'd99; channel_mask = 2'b11;
    tick();
    check_all_zero("rst_upd");
    rst = 1'b0;
    tick();
    model_reset(1'b0, 99, 2'b11);
    check("rst_restart_run", 32'(running), 32'd1);
    for (int s = 0; s < 16; s++) begin
      sample(16'h8064, 16'h8000);
      if (s == 14 || s == 15) check_model($sformatf("rst_rerun%0d", s));
    end
    check("rst_rerun_chans", 32'(over_threshold_channels), 32'b01);

    // Randomized runs against the model.
    for (int t = 0; t < 12; t++) begin
      start(1'($urandom_range(0, 1)), 15'($urandom_range(14000, 19000)),
            2'($urandom_range(0, 3)));
      for (int s = 0; s < 32; s++) begin
        sample(16'($urandom), 16'($urandom));
        if (s % BLK == BLK - 1) check_model($sformatf("rnd%0d_%0d", t, s));
      end
    end

    enable = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
